// File: rtl/ga_pkg.sv
// Shared gate-array constants: default timing/divider values for the interrupt and sync logic.
package ga_pkg;
  localparam int GA_CNT_W     = 6;
  localparam int GA_LINE_W    = 9;
  localparam int GA_IRQ_DIV   = 52;
  localparam int GA_VS_RESYNC = 2;
  localparam int GA_HS_DLY    = 2;
  localparam int GA_HS_LEN    = 4;
  localparam int GA_VS_LEN    = 26;

  typedef enum logic {
    SRC_DIV = 1'b0,
    SRC_PRI = 1'b1
  } irq_src_e;
endpackage

// File: rtl/ga_sync_shaper.sv
// HSYNC_O/VSYNC_O shaping: delayed, length-limited HSYNC and fixed-length VSYNC in lines.
module ga_sync_shaper
  import ga_pkg::*;
#(
  parameter int HS_DLY = GA_HS_DLY,
  parameter int HS_LEN = GA_HS_LEN,
  parameter int VS_LEN = GA_VS_LEN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cclk_en,
  input  logic i_hs_rise,
  input  logic i_hs_end,
  input  logic i_vs_rise,
  output logic o_hsync,
  output logic o_vsync
);
  localparam int PW = $clog2(HS_DLY + HS_LEN + 1);
  localparam int VW = $clog2(VS_LEN + 1);

  logic          r_track;
  logic [PW-1:0] r_pos;
  logic          r_hsync;
  logic [PW-1:0] w_pos_nxt;
  logic [VW-1:0] r_vcnt;
  logic          r_vsync;

  assign w_pos_nxt = r_pos + PW'(1);

  // r_pos counts char clocks since the HSYNC_I rise; a fall at any point abandons the pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_track <= 1'b0;
      r_pos   <= '0;
      r_hsync <= 1'b0;
    end else if (i_hs_rise) begin
      r_track <= 1'b1;
      r_pos   <= '0;
      r_hsync <= 1'b0;
    end else if (i_hs_end) begin
      r_track <= 1'b0;
      r_hsync <= 1'b0;
    end else if (i_cclk_en && r_track) begin
      r_pos <= w_pos_nxt;
      if (w_pos_nxt == PW'(HS_DLY + HS_LEN)) begin
        r_track <= 1'b0;
        r_hsync <= 1'b0;
      end else if (w_pos_nxt == PW'(HS_DLY)) begin
        r_hsync <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vsync <= 1'b0;
      r_vcnt  <= '0;
    end else if (i_vs_rise) begin
      r_vsync <= 1'b1;
      r_vcnt  <= '0;
    end else if (i_hs_end && r_vsync) begin
      if (r_vcnt == VW'(VS_LEN - 1)) r_vsync <= 1'b0;
      else r_vcnt <= r_vcnt + VW'(1);
    end
  end

  assign o_hsync = r_hsync;
  assign o_vsync = r_vsync;
endmodule

// File: rtl/ga_irqgen.sv
// Gate-array interrupt generator: HSYNC divider with VSYNC resync, plus sync shaping.
// Define GA_PRI_EN to add the programmable raster-line interrupt.
module ga_irqgen
  import ga_pkg::*;
#(
  parameter int CNT_W     = GA_CNT_W,
  parameter int IRQ_DIV   = GA_IRQ_DIV,
  parameter int VS_RESYNC = GA_VS_RESYNC,
  parameter int HS_DLY    = GA_HS_DLY,
  parameter int HS_LEN    = GA_HS_LEN,
  parameter int VS_LEN    = GA_VS_LEN,
  parameter int LINE_W    = GA_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cclk_en,
  input  logic              HSYNC_I,
  input  logic              VSYNC_I,
  input  logic              int_ack,
  input  logic              irq_clr,
  input  logic [LINE_W-1:0] pri_line,
  output logic              HSYNC_O,
  output logic              VSYNC_O,
  output logic              INT_N,
  output logic              int_src
);
  logic             r_hs, r_vs, r_smp_vld;
  logic             w_hs_rise, w_hs_end, w_vs_rise;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_rs_cnt;
  logic             r_rs_arm, w_rs_hit;
  logic             w_set_div, w_set_int, w_set_pri;
  logic             r_int_pend, r_pri_pend, r_int_n;

  // First sample after reset only primes the edge detectors, so a sync already in progress is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
      r_smp_vld <= 1'b0;
    end else if (cclk_en) begin
      r_hs      <= HSYNC_I;
      r_vs      <= VSYNC_I;
      r_smp_vld <= 1'b1;
    end
  end

  assign w_hs_rise = cclk_en & r_smp_vld & ~r_hs & HSYNC_I;
  assign w_hs_end  = cclk_en & r_smp_vld & r_hs & ~HSYNC_I;
  assign w_vs_rise = cclk_en & r_smp_vld & ~r_vs & VSYNC_I;
  assign w_rs_hit  = w_hs_end & r_rs_arm & ~w_vs_rise & (r_rs_cnt == CNT_W'(VS_RESYNC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rs_arm <= 1'b0;
      r_rs_cnt <= '0;
    end else if (w_vs_rise) begin
      r_rs_arm <= 1'b1;
      r_rs_cnt <= '0;
    end else if (w_rs_hit) begin
      r_rs_arm <= 1'b0;
    end else if (w_hs_end && r_rs_arm) begin
      r_rs_cnt <= r_rs_cnt + CNT_W'(1);
    end
  end

  // Precedence on the count: event update, then ack clears the MSB, then irq_clr wipes everything.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_set_div = 1'b0;
    if (w_rs_hit) begin
      w_set_div = r_cnt[CNT_W-1];
      w_cnt_nxt = '0;
    end else if (w_hs_end) begin
      if (r_cnt == CNT_W'(IRQ_DIV - 1)) begin
        w_cnt_nxt = '0;
        w_set_div = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
    if (int_ack) w_cnt_nxt[CNT_W-1] = 1'b0;
    if (irq_clr) w_cnt_nxt = '0;
  end

`ifdef GA_PRI_EN
  logic [LINE_W-1:0] r_line, w_line_nxt;
  logic              w_pri_on;

  assign w_pri_on   = |pri_line;
  assign w_line_nxt = w_rs_hit ? '0 : r_line + LINE_W'(1);
  assign w_set_pri  = w_hs_end & w_pri_on & (w_line_nxt == pri_line);
  assign w_set_int  = w_set_div & ~w_pri_on;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_line <= '0;
    else if (w_hs_end) r_line <= w_line_nxt;
  end
`else
  logic w_unused_pri;

  assign w_unused_pri = ^pri_line;
  assign w_set_pri    = 1'b0;
  assign w_set_int    = w_set_div;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_int_pend <= 1'b0;
      r_pri_pend <= 1'b0;
      r_int_n    <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (irq_clr) r_int_pend <= 1'b0;
      else if (w_set_int) r_int_pend <= 1'b1;
      else if (int_ack && !r_pri_pend) r_int_pend <= 1'b0;
      if (w_set_pri) r_pri_pend <= 1'b1;
      else if (int_ack) r_pri_pend <= 1'b0;
      r_int_n <= ~(r_int_pend | r_pri_pend);
    end
  end

  assign INT_N   = r_int_n;
  assign int_src = r_pri_pend ? SRC_PRI : SRC_DIV;

  ga_sync_shaper #(
    .HS_DLY(HS_DLY),
    .HS_LEN(HS_LEN),
    .VS_LEN(VS_LEN)
  ) u_shaper (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_cclk_en(cclk_en),
    .i_hs_rise(w_hs_rise),
    .i_hs_end (w_hs_end),
    .i_vs_rise(w_vs_rise),
    .o_hsync  (HSYNC_O),
    .o_vsync  (VSYNC_O)
  );
endmodule

// File: tb/tb_ga_irqgen.sv
// Scoreboard bench for ga_irqgen: expected interrupt lines and HSYNC_O levels queued at drive time.
module tb_ga_irqgen;
  logic       clk;
  logic       reset;
  logic       cclk_en;
  logic       HSYNC_I;
  logic       VSYNC_I;
  logic       int_ack;
  logic       irq_clr;
  logic [8:0] pri_line;
  logic       HSYNC_O;
  logic       VSYNC_O;
  logic       INT_N;
  logic       int_src;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    int   line;
    logic src;
  } exp_t;

  exp_t exp_q[$];
  logic hs_q[$];

  ga_irqgen dut (
    .clk     (clk),
    .reset   (reset),
    .cclk_en (cclk_en),
    .HSYNC_I (HSYNC_I),
    .VSYNC_I (VSYNC_I),
    .int_ack (int_ack),
    .irq_clr (irq_clr),
    .pri_line(pri_line),
    .HSYNC_O (HSYNC_O),
    .VSYNC_O (VSYNC_O),
    .INT_N   (INT_N),
    .int_src (int_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic hs, input logic vs, input logic clr, input logic ack);
    @(negedge clk);
    HSYNC_I = hs;
    VSYNC_I = vs;
    irq_clr = clr;
    int_ack = ack;
    cclk_en = 1'b1;
    @(negedge clk);
    cclk_en = 1'b0;
    irq_clr = 1'b0;
    int_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic hs_line(input logic vs);
    tick(1'b1, vs, 1'b0, 1'b0);
    tick(1'b0, vs, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic clr, input logic ack);
    @(negedge clk);
    irq_clr = clr;
    int_ack = ack;
    @(negedge clk);
    irq_clr = 1'b0;
    int_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    HSYNC_I = 1'b0;
    VSYNC_I = 1'b0;
    cclk_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Any INT_N fall is matched against the head of exp_q, then acknowledged.
  task automatic run_lines(input int n, input logic vs, input int base);
    exp_t e;
    for (int i = 1; i <= n; i++) begin
      hs_line(vs);
      if (INT_N === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL irq_unexpected: INT_N=0 after line %0d, required 1", base + i);
        end else begin
          e = exp_q.pop_front();
          if (base + i != e.line) begin
            errors++;
            $display("FAIL irq_line: interrupt after line %0d, required line %0d", base + i, e.line);
          end
          checks++;
          if (int_src !== e.src) begin
            errors++;
            $display("FAIL irq_src: int_src=%b, required %b", int_src, e.src);
          end
        end
        pulse(1'b0, 1'b1);
        checks++;
        if (INT_N !== 1'b1) begin
          errors++;
          $display("FAIL irq_ack: INT_N=%b after int_ack, required 1", INT_N);
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected interrupts never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_cnt(input string name, input logic [5:0] req);
    checks++;
    if (dut.r_cnt !== req) begin
      errors++;
      $display("FAIL %s: counter=%0d, required %0d", name, dut.r_cnt, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: value=%b, required %b", name, act, req);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_bit("reset_int_n", INT_N, 1'b1);
    check_bit("reset_hsync_o", HSYNC_O, 1'b0);
    check_bit("reset_vsync_o", VSYNC_O, 1'b0);
    check_bit("reset_int_src", int_src, 1'b0);
    check_cnt("reset_cnt", 6'd0);
  endtask

  task automatic test_divider();
    do_reset();
    exp_q.push_back('{line: 52, src: 1'b0});
    exp_q.push_back('{line: 104, src: 1'b0});
    run_lines(104, 1'b0, 0);
    check_drained("div_falls");
  endtask

  task automatic test_ack_msb();
    do_reset();
    run_lines(40, 1'b0, 0);
    pulse(1'b0, 1'b1);
    check_bit("ack40_int_n", INT_N, 1'b1);
    check_cnt("ack40_cnt", 6'd8);
    exp_q.push_back('{line: 44, src: 1'b0});
    run_lines(50, 1'b0, 0);
    check_drained("ack40_next");
  endtask

  task automatic test_resync();
    do_reset();
    run_lines(35, 1'b0, 0);
    exp_q.push_back('{line: 2, src: 1'b0});
    run_lines(2, 1'b1, 0);
    check_drained("rs35_irq");
    check_cnt("rs35_cnt", 6'd0);
    check_bit("rs35_vsync_o", VSYNC_O, 1'b1);
    do_reset();
    run_lines(20, 1'b0, 0);
    run_lines(2, 1'b1, 20);
    check_cnt("rs20_cnt", 6'd0);
    run_lines(23, 1'b0, 22);
    check_bit("vs_len_25", VSYNC_O, 1'b1);
    run_lines(1, 1'b0, 45);
    check_bit("vs_len_26", VSYNC_O, 1'b0);
    check_cnt("rs20_cnt_after", 6'd24);
  endtask

  task automatic test_clr_wrap();
    do_reset();
    run_lines(51, 1'b0, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_bit("clr_wrap_int_n", INT_N, 1'b1);
    check_cnt("clr_wrap_cnt", 6'd0);
    do_reset();
    run_lines(51, 1'b0, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_bit("set_beats_ack", INT_N, 1'b0);
    pulse(1'b1, 1'b0);
    check_bit("clr_pending", INT_N, 1'b1);
  endtask

  task automatic test_hsync_shape();
    logic hs;
    logic req;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      hs = (k < 10);
      hs_q.push_back(k >= 2 && k <= 5);
      tick(hs, 1'b0, 1'b0, 1'b0);
      req = hs_q.pop_front();
      checks++;
      if (HSYNC_O !== req) begin
        errors++;
        $display("FAIL hs_long_k%0d: HSYNC_O=%b, required %b", k, HSYNC_O, req);
      end
    end
    for (int k = 0; k < 6; k++) begin
      hs = (k == 0);
      hs_q.push_back(1'b0);
      tick(hs, 1'b0, 1'b0, 1'b0);
      req = hs_q.pop_front();
      checks++;
      if (HSYNC_O !== req) begin
        errors++;
        $display("FAIL hs_short_k%0d: HSYNC_O=%b, required %b", k, HSYNC_O, req);
      end
    end
  endtask

  task automatic test_midsync_reset();
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    check_bit("mid_hsync_on", HSYNC_O, 1'b1);
    check_bit("mid_vsync_on", VSYNC_O, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_bit("mid_rst_hsync", HSYNC_O, 1'b0);
    check_bit("mid_rst_vsync", VSYNC_O, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (HSYNC_O !== 1'b0 || VSYNC_O !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_fresh_k%0d: HSYNC_O=%b VSYNC_O=%b, required 0 0", k, HSYNC_O, VSYNC_O);
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("mid_fresh_hsync", HSYNC_O, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_pri();
    do_reset();
`ifdef GA_PRI_EN
    pri_line = 9'd100;
    exp_q.push_back('{line: 100, src: 1'b1});
    run_lines(110, 1'b0, 0);
    check_drained("pri_line100");
`else
    pri_line = 9'd10;
    exp_q.push_back('{line: 52, src: 1'b0});
    run_lines(60, 1'b0, 0);
    check_drained("pri_ignored");
`endif
    check_bit("pri_src_idle", int_src, 1'b0);
    pri_line = 9'd0;
  endtask

  initial begin
    reset    = 1'b1;
    cclk_en  = 1'b0;
    HSYNC_I  = 1'b0;
    VSYNC_I  = 1'b0;
    int_ack  = 1'b0;
    irq_clr  = 1'b0;
    pri_line = 9'd0;
    test_reset();
    test_divider();
    test_ack_msb();
    test_resync();
    test_clr_wrap();
    test_hsync_shape();
    test_midsync_reset();
    test_pri();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
